alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter DECIMAL_SUPPORT, default 1, 1 enables BCD ADC/SBC and 0 ignores flag_d_in (2A03 mode).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  operation request.
REQ-005 req_ready  out  1  controller can accept a request.
REQ-006 req_op  in  4  operation code, alu_op_t.
REQ-007 req_a  in  8  operand A (accumulator/memory).
REQ-008 req_b  in  8  operand B.
REQ-009 flag_c_in  in  1  current carry flag.
REQ-010 flag_d_in  in  1  current decimal flag.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  consumer accepts result.
REQ-013 rsp_data  out  8  result byte.
REQ-014 rsp_n, rsp_v, rsp_z, rsp_c  out  1 each  resulting flags.
REQ-015 rsp_err  out  1  illegal opcode reported.

Function
REQ-016 Ops: ADC, SBC, AND, ORA, EOR, CMP, ASL, LSR, ROL, ROR; other codes are illegal.
REQ-017 FSM states IDLE, EXEC, DADJ, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-018 IDLE: req_valid&req_ready latches op, operands, C, D and moves to EXEC.
REQ-019 EXEC drives the ALU once and registers result, carry, half-carry, overflow; it goes to DADJ only for ADC/SBC with latched D=1 and DECIMAL_SUPPORT=1, else to RESP.
REQ-020 ALU mapping: ADC = A+B+C; SBC = A+~B+C; CMP = A+~B+1; ASL = A+A+0; ROL = A+A+C; LSR = shift with carry-in 0; ROR = shift with carry-in C; AND/ORA/EOR via logic enables.
REQ-021 DADJ uses the binary result r, carry c1 and half-carry h1 to add one adjust constant through the ALU with carry-in 0.
REQ-022 ADC adjust: lo = h1 | r[3:0]>9; hi = c1 | r>0x99; add lo*0x06 + hi*0x60; final C = c1 | hi.
REQ-023 SBC adjust: lo = ~h1, hi = ~c1; add lo-only 0xFA, hi-only 0xA0, both 0x9A; final C = c1.
REQ-024 N = result[7] and Z = (result==0) from the final result; V comes from the binary pass (ADC/SBC only, else 0).
REQ-025 C for AND/ORA/EOR equals latched flag_c_in; CMP sets rsp_data = A and C = A>=B.
REQ-026 Illegal op: no DADJ; rsp_data=0xFF, flags 0, rsp_err=1.
REQ-027 Latency: rsp_valid asserts 2 cycles after request handshake (binary) or 3 (decimal).
REQ-028 RESP holds all rsp_* stable until rsp_ready=1, then goes to IDLE; no request accepted the same cycle.
REQ-029 Operand changes on req_* after acceptance have no effect.

Reset
REQ-030 reset_n low asynchronously forces IDLE, rsp_valid=0, rsp_data=0x00, all rsp flags and rsp_err 0; req_ready=1 after release.
REQ-031 Reset during EXEC/DADJ/RESP discards the operation without any response.

Structure
REQ-032 Package alu_pkg holds alu_op_t, the state enum, and the BCD constants 0x06, 0x60, 0xFA, 0xA0, 0x9A.
REQ-033 One sub-module: the existing combinational alu, instantiated once and shared by EXEC and DADJ.

Verification
REQ-034 ADC A=0x50 B=0x50 C=0 D=0 -> data 0x A0, V=1, N=1, C=0, valid 2 cycles after accept.
REQ-035 ADC A=0x99 B=0x01 C=0 D=1 -> data 0x00, C=1, Z=1, valid 3 cycles after accept; with DECIMAL_SUPPORT=0 -> 0x9A, C=0.
REQ-036 SBC A=0x00 B=0x01 C=1 D=1 -> data 0x99, C=0; SBC A=0x10 B=0x01 C=1 D=1 -> 0x09, C=1.
REQ-037 ROR A=0x01 C=1 -> data 0x80, C=1, N=1; CMP A=0x10 B=0x20 -> data 0x10, C=0, N=1.
REQ-038 rsp_ready held low 5 cycles -> outputs stable, req_ready=0 throughout; illegal op -> 0xFF, rsp_err=1.
REQ-039 reset_n pulsed low during DADJ -> no rsp_valid, IDLE with req_ready=1 next cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU controller and its combinational ALU.
package alu_pkg;

  // Operation codes; encodings above OP_ROR are illegal.
  typedef enum logic [3:0] {
    OP_ADC = 4'h0,
    OP_SBC = 4'h1,
    OP_AND = 4'h2,
    OP_ORA = 4'h3,
    OP_EOR = 4'h4,
    OP_CMP = 4'h5,
    OP_ASL = 4'h6,
    OP_LSR = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9
  } alu_op_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DADJ = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Function selects understood by the combinational ALU.
  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_AND = 3'd1,
    FN_ORA = 3'd2,
    FN_EOR = 3'd3,
    FN_SHR = 3'd4
  } alu_fn_t;

  // BCD correction constants added during decimal adjust.
  localparam logic [7:0] BCD_ADC_LO  = 8'h06;
  localparam logic [7:0] BCD_ADC_HI  = 8'h60;
  localparam logic [7:0] BCD_SBC_LO  = 8'hFA;
  localparam logic [7:0] BCD_SBC_HI  = 8'hA0;
  localparam logic [7:0] BCD_SBC_ALL = 8'h9A;

  // True for any encoding that names a supported operation.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'h9);
  endfunction

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational 8-bit ALU: adder with carry/half-carry/overflow, logic ops,
// and a right shift whose incoming bit 7 is the carry input.
module alu_ctrl_alu
  import alu_pkg::*;
(
  input  alu_fn_t     fn,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        c_in,
  output logic [7:0]  y,
  output logic        c_out,
  output logic        h_out,
  output logic        v_out
);

  logic [8:0] sum;
  logic [4:0] lo_sum;

  assign sum    = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
  assign lo_sum = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c_in};

  // Select the result and status bits for the requested function.
  always_comb begin
    y     = sum[7:0];
    c_out = sum[8];
    h_out = lo_sum[4];
    v_out = (a[7] == b[7]) && (sum[7] != a[7]);
    case (fn)
      FN_AND: begin
        y     = a & b;
        c_out = 1'b0;
        h_out = 1'b0;
        v_out = 1'b0;
      end
      FN_ORA: begin
        y     = a | b;
        c_out = 1'b0;
        h_out = 1'b0;
        v_out = 1'b0;
      end
      FN_EOR: begin
        y     = a ^ b;
        c_out = 1'b0;
        h_out = 1'b0;
        v_out = 1'b0;
      end
      FN_SHR: begin
        y     = {c_in, a[7:1]};
        c_out = a[0];
        h_out = 1'b0;
        v_out = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Request/response controller around a shared ALU: one binary pass, an
// optional BCD adjust pass, then a held response until consumed.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter bit DECIMAL_SUPPORT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  alu_op_t    req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       flag_c_in,
  input  logic       flag_d_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_n,
  output logic       rsp_v,
  output logic       rsp_z,
  output logic       rsp_c,
  output logic       rsp_err
);

  // Adjust constant for the decimal pass from the binary result and carries.
  function automatic logic [7:0] dec_adj_value(input logic is_sbc, input logic [7:0] r,
                                               input logic c1, input logic h1);
    logic lo;
    logic hi;
    logic [7:0] k;
    k = 8'h00;
    if (is_sbc) begin
      lo = ~h1;
      hi = ~c1;
      case ({hi, lo})
        2'b01:   k = BCD_SBC_LO;
        2'b10:   k = BCD_SBC_HI;
        2'b11:   k = BCD_SBC_ALL;
        default: k = 8'h00;
      endcase
    end else begin
      lo = h1 | (r[3:0] > 4'd9);
      hi = c1 | (r > 8'h99);
      k  = (lo ? BCD_ADC_LO : 8'h00) | (hi ? BCD_ADC_HI : 8'h00);
    end
    return k;
  endfunction

  // Final carry after the decimal pass.
  function automatic logic dec_carry(input logic is_sbc, input logic [7:0] r, input logic c1);
    if (is_sbc) return c1;
    return c1 | (r > 8'h99);
  endfunction

  state_t     state_q, state_d;
  alu_op_t    op_q;
  logic [7:0] a_q, b_q;
  logic       c_q, d_q;
  logic [7:0] r_q;
  logic       c1_q, h1_q, v1_q;

  alu_fn_t    alu_fn;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_cin, alu_c, alu_h, alu_v;

  logic       is_sbc_q;
  logic       go_dadj;

  logic [7:0] fin_data;
  logic       fin_n, fin_v, fin_z, fin_c, fin_err;

  logic [7:0] rsp_data_q;
  logic       rsp_n_q, rsp_v_q, rsp_z_q, rsp_c_q, rsp_err_q;

  assign is_sbc_q = (op_q == OP_SBC);
  assign go_dadj  = DECIMAL_SUPPORT && d_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

  alu_ctrl_alu u_alu (
    .fn    (alu_fn),
    .a     (alu_a),
    .b     (alu_b),
    .c_in  (alu_cin),
    .y     (alu_y),
    .c_out (alu_c),
    .h_out (alu_h),
    .v_out (alu_v)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = go_dadj ? ST_DADJ : ST_RESP;
      ST_DADJ: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request; later changes on req_* are ignored.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req_valid) begin
      op_q <= req_op;
      a_q  <= req_a;
      b_q  <= req_b;
      c_q  <= flag_c_in;
      d_q  <= flag_d_in;
    end
  end

  // ALU operand steering: binary pass in EXEC, adjust add in DADJ.
  always_comb begin
    alu_fn  = FN_ADD;
    alu_a   = a_q;
    alu_b   = b_q;
    alu_cin = 1'b0;
    if (state_q == ST_DADJ) begin
      alu_a = r_q;
      alu_b = dec_adj_value(is_sbc_q, r_q, c1_q, h1_q);
    end else begin
      case (op_q)
        OP_ADC: alu_cin = c_q;
        OP_SBC: begin
          alu_b   = ~b_q;
          alu_cin = c_q;
        end
        OP_CMP: begin
          alu_b   = ~b_q;
          alu_cin = 1'b1;
        end
        OP_ASL: alu_b = a_q;
        OP_ROL: begin
          alu_b   = a_q;
          alu_cin = c_q;
        end
        OP_LSR: alu_fn = FN_SHR;
        OP_ROR: begin
          alu_fn  = FN_SHR;
          alu_cin = c_q;
        end
        OP_AND: alu_fn = FN_AND;
        OP_ORA: alu_fn = FN_ORA;
        OP_EOR: alu_fn = FN_EOR;
        default: ;
      endcase
    end
  end

  // Keep the binary-pass result for the adjust pass.
  always_ff @(posedge clk) begin
    if (state_q == ST_EXEC) begin
      r_q  <= alu_y;
      c1_q <= alu_c;
      h1_q <= alu_h;
      v1_q <= alu_v;
    end
  end

  // Final response value for whichever pass is completing this cycle.
  always_comb begin
    fin_data = alu_y;
    fin_n    = alu_y[7];
    fin_z    = (alu_y == 8'h00);
    fin_v    = 1'b0;
    fin_c    = alu_c;
    fin_err  = 1'b0;
    if (state_q == ST_DADJ) begin
      fin_v = v1_q;
      fin_c = dec_carry(is_sbc_q, r_q, c1_q);
    end else if (!op_is_legal(op_q)) begin
      fin_data = 8'hFF;
      fin_n    = 1'b0;
      fin_z    = 1'b0;
      fin_c    = 1'b0;
      fin_err  = 1'b1;
    end else begin
      case (op_q)
        OP_ADC, OP_SBC:         fin_v = alu_v;
        OP_CMP:                 fin_data = a_q;
        OP_AND, OP_ORA, OP_EOR: fin_c = c_q;
        default: ;
      endcase
    end
  end

  // Response registers, loaded on entry to RESP and held until consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_q <= 8'h00;
      rsp_n_q    <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_z_q    <= 1'b0;
      rsp_c_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if ((state_q == ST_EXEC || state_q == ST_DADJ) && state_d == ST_RESP) begin
      rsp_data_q <= fin_data;
      rsp_n_q    <= fin_n;
      rsp_v_q    <= fin_v;
      rsp_z_q    <= fin_z;
      rsp_c_q    <= fin_c;
      rsp_err_q  <= fin_err;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_n    = rsp_n_q;
  assign rsp_v    = rsp_v_q;
  assign rsp_z    = rsp_z_q;
  assign rsp_c    = rsp_c_q;
  assign rsp_err  = rsp_err_q;

endmodule
